// File: rtl/serial_frame_tx.sv
// ---------------------------------------------------------------------------
// serial_frame_tx
//   Framing serializer. It accepts an N-bit word over a valid/ready handshake
//   and sends it on a single idle-high serial line, LSB first, as
//   start bit, N data bits, an optional parity bit, and a stop bit. Each bit
//   is held for DIV clocks.
//
// Parameters
//   N           data width in bits (>= 1)
//   DIV         clocks per serial bit (>= 1)
//   PARITY_EN   1 = insert a parity bit after the data bits
//   PARITY_ODD  0 = even parity, 1 = odd parity (ignored when PARITY_EN = 0)
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   asynchronous, active-high reset
//   in_valid  in   in_data holds a word to send
//   in_ready  out  word can be accepted (high only while idle)
//   in_data   in   parallel word, sampled only on the accept edge
//   tx        out  registered serial line, idle-high
//   busy      out  a frame is in progress
//   done      out  one-cycle pulse in the first idle cycle after a frame
// ---------------------------------------------------------------------------
module serial_frame_tx #(
  parameter int N          = 8,
  parameter int DIV        = 4,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         tx,
  output logic         busy,
  output logic         done
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = (N > 1) ? $clog2(N) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);

  localparam logic PAR_ODD_BIT = (PARITY_ODD != 0);
  localparam logic HAS_PARITY  = (PARITY_EN != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t         r_state;
  state_t         w_state_next;

  logic [DW-1:0]  r_div_cnt;
  logic [DW-1:0]  w_div_cnt_next;
  logic [BW-1:0]  r_bit_cnt;
  logic [BW-1:0]  w_bit_cnt_next;
  logic [N-1:0]   r_shreg;
  logic [N-1:0]   w_shreg_next;
  logic           r_parity;
  logic           w_parity_next;
  logic           r_tx;
  logic           w_tx_next;
  logic           r_done;
  logic           w_done_next;

  logic           w_accept;
  logic           w_bit_end;

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign tx        = r_tx;
  assign done      = r_done;

  assign w_accept  = in_valid && (r_state == S_IDLE);
  // With DIV = 1 the counter never leaves 0, so every state ends each clock.
  assign w_bit_end = (r_div_cnt == DIV_LAST);

  // -------------------------------------------------------------------------
  // State, counters and datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_div_cnt <= '0;
      r_bit_cnt <= '0;
      r_shreg   <= '0;
      r_parity  <= 1'b0;
      r_tx      <= 1'b1;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_div_cnt <= w_div_cnt_next;
      r_bit_cnt <= w_bit_cnt_next;
      r_shreg   <= w_shreg_next;
      r_parity  <= w_parity_next;
      r_tx      <= w_tx_next;
      r_done    <= w_done_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and datapath logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next   = r_state;
    w_div_cnt_next = r_div_cnt;
    w_bit_cnt_next = r_bit_cnt;
    w_shreg_next   = r_shreg;
    w_parity_next  = r_parity;
    w_done_next    = 1'b0;
    w_tx_next      = 1'b1;

    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_next   = S_START;
          w_shreg_next   = in_data;
          w_parity_next  = (^in_data) ^ PAR_ODD_BIT;
          w_div_cnt_next = '0;
          w_bit_cnt_next = '0;
        end
      end

      S_START: begin
        if (w_bit_end) begin
          w_state_next   = S_DATA;
          w_div_cnt_next = '0;
        end else begin
          w_div_cnt_next = r_div_cnt + DW'(1);
        end
      end

      S_DATA: begin
        if (w_bit_end) begin
          w_div_cnt_next = '0;
          // Plain right shift keeps the expression legal for N = 1.
          w_shreg_next   = r_shreg >> 1;
          if (r_bit_cnt == BIT_LAST) begin
            w_bit_cnt_next = '0;
            w_state_next   = HAS_PARITY ? S_PARITY : S_STOP;
          end else begin
            w_bit_cnt_next = r_bit_cnt + BW'(1);
          end
        end else begin
          w_div_cnt_next = r_div_cnt + DW'(1);
        end
      end

      S_PARITY: begin
        if (w_bit_end) begin
          w_state_next   = S_STOP;
          w_div_cnt_next = '0;
        end else begin
          w_div_cnt_next = r_div_cnt + DW'(1);
        end
      end

      S_STOP: begin
        if (w_bit_end) begin
          w_state_next   = S_IDLE;
          w_div_cnt_next = '0;
          w_done_next    = 1'b1;
        end else begin
          w_div_cnt_next = r_div_cnt + DW'(1);
        end
      end

      default: begin
        w_state_next   = S_IDLE;
        w_div_cnt_next = '0;
        w_bit_cnt_next = '0;
      end
    endcase

    // tx is registered from the *next* state and shift register so the line
    // changes on the same edge as the state, e.g. the start bit appears in
    // the first cycle after the accept edge.
    unique case (w_state_next)
      S_IDLE:   w_tx_next = 1'b1;
      S_START:  w_tx_next = 1'b0;
      S_DATA:   w_tx_next = w_shreg_next[0];
      S_PARITY: w_tx_next = w_parity_next;
      S_STOP:   w_tx_next = 1'b1;
      default:  w_tx_next = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// ---------------------------------------------------------------------------
// tb_serial_frame_tx
//   Directed bench for serial_frame_tx. Four instances cover the default
//   configuration, even parity, odd parity and DIV = 1. Expected frames are
//   written as bit vectors where bit k is the k-th bit on the line.
// ---------------------------------------------------------------------------
module tb_serial_frame_tx;

  localparam int IDX_DEF = 0;
  localparam int IDX_PE  = 1;
  localparam int IDX_PO  = 2;
  localparam int IDX_D1  = 3;

  logic       clk;
  logic       reset;
  logic [3:0] v;
  logic [7:0] d [4];
  logic [3:0] txo;
  logic [3:0] bz;
  logic [3:0] dn;
  logic [3:0] rd;

  int n_chk;
  int n_fail;

  serial_frame_tx #(.N(8), .DIV(4), .PARITY_EN(0), .PARITY_ODD(0)) u_def (
    .clk(clk), .reset(reset), .in_valid(v[0]), .in_ready(rd[0]),
    .in_data(d[0]), .tx(txo[0]), .busy(bz[0]), .done(dn[0])
  );

  serial_frame_tx #(.N(8), .DIV(4), .PARITY_EN(1), .PARITY_ODD(0)) u_pe (
    .clk(clk), .reset(reset), .in_valid(v[1]), .in_ready(rd[1]),
    .in_data(d[1]), .tx(txo[1]), .busy(bz[1]), .done(dn[1])
  );

  serial_frame_tx #(.N(8), .DIV(4), .PARITY_EN(1), .PARITY_ODD(1)) u_po (
    .clk(clk), .reset(reset), .in_valid(v[2]), .in_ready(rd[2]),
    .in_data(d[2]), .tx(txo[2]), .busy(bz[2]), .done(dn[2])
  );

  serial_frame_tx #(.N(8), .DIV(1), .PARITY_EN(0), .PARITY_ODD(0)) u_d1 (
    .clk(clk), .reset(reset), .in_valid(v[3]), .in_ready(rd[3]),
    .in_data(d[3]), .tx(txo[3]), .busy(bz[3]), .done(dn[3])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents a word and steps through the accept edge; in_valid drops after.
  task automatic accept(input int sel, input logic [7:0] word, input string tag);
    v[sel] = 1'b1;
    d[sel] = word;
    chk({tag, " ready before accept"}, rd[sel], 1'b1);
    step(1);
    v[sel] = 1'b0;
  endtask

  // Called in the first cycle after the accept edge. Checks every frame
  // cycle, then the done cycle.
  task automatic check_frame(input int sel, input logic [11:0] bits, input int nbits,
                             input int div, input bit toggle, input string tag);
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < div; c++) begin
        chk($sformatf("%s tx bit%0d clk%0d", tag, b, c), txo[sel], bits[b]);
        chk($sformatf("%s busy bit%0d clk%0d", tag, b, c), bz[sel], 1'b1);
        chk($sformatf("%s done bit%0d clk%0d", tag, b, c), dn[sel], 1'b0);
        if (toggle) d[sel] = ~d[sel];
        step(1);
      end
    end
    chk({tag, " done pulse"}, dn[sel], 1'b1);
    chk({tag, " tx idle at done"}, txo[sel], 1'b1);
    chk({tag, " busy at done"}, bz[sel], 1'b0);
    chk({tag, " ready at done"}, rd[sel], 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  initial begin
    n_chk  = 0;
    n_fail = 0;
    reset  = 1'b1;
    v      = '0;
    for (int i = 0; i < 4; i++) d[i] = '0;
    step(2);
    reset = 1'b0;
    step(1);

    // Reset state of every instance
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("reset tx u%0d", i), txo[i], 1'b1);
      chk($sformatf("reset busy u%0d", i), bz[i], 1'b0);
      chk($sformatf("reset done u%0d", i), dn[i], 1'b0);
      chk($sformatf("reset ready u%0d", i), rd[i], 1'b1);
    end

    // in_valid dropped before any edge sees it: nothing happens
    v[IDX_DEF] = 1'b1;
    d[IDX_DEF] = 8'h55;
    #3;
    v[IDX_DEF] = 1'b0;
    step(1);
    chk("drop valid busy", bz[IDX_DEF], 1'b0);
    chk("drop valid tx", txo[IDX_DEF], 1'b1);
    step(1);
    chk("drop valid tx later", txo[IDX_DEF], 1'b1);

    // 1. Defaults, 8'hA5 -> 0,1,0,1,0,0,1,0,1,1
    accept(IDX_DEF, 8'hA5, "a5");
    check_frame(IDX_DEF, 12'b00_1101001010, 10, 4, 1'b0, "a5");
    step(1);
    chk("a5 done one cycle", dn[IDX_DEF], 1'b0);

    // 2. Reset at data bit 3
    accept(IDX_DEF, 8'hA5, "rst");
    step(16);
    chk("rst pre bit3 tx", txo[IDX_DEF], 1'b0);
    chk("rst pre busy", bz[IDX_DEF], 1'b1);
    reset = 1'b1;
    #1;
    chk("rst async tx", txo[IDX_DEF], 1'b1);
    chk("rst async busy", bz[IDX_DEF], 1'b0);
    chk("rst async ready", rd[IDX_DEF], 1'b1);
    chk("rst async done", dn[IDX_DEF], 1'b0);
    step(1);
    reset = 1'b0;
    for (int i = 0; i < 45; i++) begin
      chk($sformatf("rst no done c%0d", i), dn[IDX_DEF], 1'b0);
      chk($sformatf("rst idle tx c%0d", i), txo[IDX_DEF], 1'b1);
      step(1);
    end
    // 8'h5A -> 0,0,1,0,1,1,0,1,0,1
    accept(IDX_DEF, 8'h5A, "post rst");
    check_frame(IDX_DEF, 12'b00_1010110100, 10, 4, 1'b0, "post rst");
    step(1);

    // 3. in_valid held high: 8'h00 then 8'hFF, second accept on done edge
    v[IDX_DEF] = 1'b1;
    d[IDX_DEF] = 8'h00;
    step(1);
    d[IDX_DEF] = 8'hFF;
    check_frame(IDX_DEF, 12'b00_1000000000, 10, 4, 1'b0, "b2b 00");
    step(1);
    v[IDX_DEF] = 1'b0;
    check_frame(IDX_DEF, 12'b00_1111111110, 10, 4, 1'b0, "b2b ff");
    step(1);
    chk("b2b idle after", bz[IDX_DEF], 1'b0);

    // 4. Even parity, 8'h07 -> parity 1, 44 clocks
    accept(IDX_PE, 8'h07, "par even");
    check_frame(IDX_PE, 12'b0_1_1_00000111_0, 11, 4, 1'b0, "par even");
    step(1);
    // Odd parity, 8'h07 -> parity 0
    accept(IDX_PO, 8'h07, "par odd");
    check_frame(IDX_PO, 12'b0_1_0_00000111_0, 11, 4, 1'b0, "par odd");
    step(1);

    // 5. DIV=1, 8'h80 -> 0,0,0,0,0,0,0,0,1,1, done on clock 11
    accept(IDX_D1, 8'h80, "div1");
    check_frame(IDX_D1, 12'b00_1100000000, 10, 1, 1'b0, "div1");
    step(1);
    chk("div1 done one cycle", dn[IDX_D1], 1'b0);

    // 6. in_data toggled while busy, 8'h3C -> 0,0,1,1,1,1,0,0
    accept(IDX_DEF, 8'h3C, "toggle");
    check_frame(IDX_DEF, 12'b00_1001111000, 10, 4, 1'b1, "toggle");
    step(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
